// File: rtl/scan_seq_engine.sv
// Multi-channel step sequencer: per-channel tables of {duration, word}
// played out on out_word, with repeat count, abort and dump pulses.
//
// Ports:
//   clk_sys, rst_n      : clock, synchronous active-low reset
//   ld_we/ld_ch/ld_addr : step table write {duration, word} on ld_data
//   cfg_we              : writes cfg_last/cfg_rep of channel ld_ch
//   ch_sel, start, abort: channel request, start and stop strobes
//   out_word            : current step word (IDLE_WORD when not running)
//   busy/act_ch/intr    : running flag, channel in use, !busy level
//   done                : one-cycle pulse at normal completion
//   dump_on/dump_off    : DUMP_PW-cycle pulses on rising word bits
//   wr_err              : one-cycle pulse on a dropped write
module scan_seq_engine #(
    parameter int              NCH       = 2,
    parameter int              DEPTH     = 16,
    parameter int              TW        = 20,
    parameter int              OW        = 8,
    parameter logic [OW-1:0]   IDLE_WORD = '0,
    parameter int              DON_BIT   = 6,
    parameter int              DOFF_BIT  = 7,
    parameter int              DUMP_PW   = 4,
    localparam int             AW        = $clog2(DEPTH),
    localparam int             CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic               ld_we,
    input  logic [CW-1:0]      ld_ch,
    input  logic [AW-1:0]      ld_addr,
    input  logic [TW+OW-1:0]   ld_data,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_last,
    input  logic [7:0]         cfg_rep,
    input  logic [CW-1:0]      ch_sel,
    input  logic               start,
    input  logic               abort,
    output logic [OW-1:0]      out_word,
    output logic               busy,
    output logic [CW-1:0]      act_ch,
    output logic               done,
    output logic               intr,
    output logic               dump_on,
    output logic               dump_off,
    output logic               wr_err
);

    localparam int PCW = $clog2(DUMP_PW + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [TW-1:0]  dur_tab  [NCH][DEPTH];
    logic [OW-1:0]  word_tab [NCH][DEPTH];
    logic [AW-1:0]  last_tab [NCH];
    logic [7:0]     rep_tab  [NCH];

    logic [AW-1:0]  step;
    logic [TW-1:0]  rem;
    logic [7:0]     rep_cnt;

    logic           go;
    logic           step_end;
    logic           last_step;
    logic           finish;
    logic           wr_block;
    logic [CW-1:0]  rd_ch;
    logic [AW-1:0]  rd_idx;
    logic [TW-1:0]  rd_dur;
    logic [TW-1:0]  rd_len;
    logic [OW-1:0]  rd_word;

    logic           on_prev, off_prev;
    logic [PCW-1:0] on_cnt, off_cnt;

    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);
    assign intr  = ~busy;

    assign go        = (state == S_IDLE) && start && !abort;
    assign step_end  = busy && (rem <= TW'(1));
    assign last_step = (step == last_tab[act_ch]);
    assign finish    = step_end && last_step && (rep_cnt == 8'd0);
    assign wr_block  = busy && (ld_ch == act_ch);

    // Table lookup for the step about to be entered: step 0 of the
    // requested channel on start, otherwise the successor (or wrap).
    assign rd_ch   = (state == S_IDLE) ? ch_sel : act_ch;
    assign rd_idx  = ((state == S_IDLE) || last_step) ? '0
                                                      : step + AW'(1);
    assign rd_dur  = dur_tab[rd_ch][rd_idx];
    assign rd_word = word_tab[rd_ch][rd_idx];
    assign rd_len  = (rd_dur == '0) ? TW'(1) : rd_dur;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (go) state_nx = S_RUN;
            S_RUN: begin
                if (abort)       state_nx = S_IDLE;
                else if (finish) state_nx = S_DONE;
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            act_ch   <= '0;
            step     <= '0;
            rem      <= '0;
            rep_cnt  <= '0;
            out_word <= IDLE_WORD;
            wr_err   <= 1'b0;
        end else begin
            wr_err <= (ld_we || cfg_we) && wr_block;
            if (state == S_IDLE) act_ch <= ch_sel;
            if (go) begin
                step     <= '0;
                rem      <= rd_len;
                rep_cnt  <= rep_tab[ch_sel];
                out_word <= rd_word;
            end else if (busy) begin
                if (abort || finish) begin
                    out_word <= IDLE_WORD;
                end else if (step_end) begin
                    if (last_step) rep_cnt <= rep_cnt - 8'd1;
                    step     <= rd_idx;
                    rem      <= rd_len;
                    out_word <= rd_word;
                end else begin
                    rem <= rem - TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                last_tab[c] <= '0;
                rep_tab[c]  <= '0;
                for (int a = 0; a < DEPTH; a++) begin
                    dur_tab[c][a]  <= '0;
                    word_tab[c][a] <= IDLE_WORD;
                end
            end
        end else begin
            if (ld_we && !wr_block) begin
                dur_tab[ld_ch][ld_addr]  <= ld_data[TW+OW-1:OW];
                word_tab[ld_ch][ld_addr] <= ld_data[OW-1:0];
            end
            if (cfg_we && !wr_block) begin
                last_tab[ld_ch] <= cfg_last;
                rep_tab[ld_ch]  <= cfg_rep;
            end
        end
    end

    // Dump pulses: a rising word bit (re)loads a DUMP_PW down-counter;
    // abort kills both pulses regardless of edges seen that cycle.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            on_prev  <= IDLE_WORD[DON_BIT];
            off_prev <= IDLE_WORD[DOFF_BIT];
            on_cnt   <= '0;
            off_cnt  <= '0;
        end else begin
            on_prev  <= out_word[DON_BIT];
            off_prev <= out_word[DOFF_BIT];
            if (abort)
                on_cnt <= '0;
            else if (out_word[DON_BIT] && !on_prev)
                on_cnt <= PCW'(DUMP_PW);
            else if (on_cnt != '0)
                on_cnt <= on_cnt - PCW'(1);
            if (abort)
                off_cnt <= '0;
            else if (out_word[DOFF_BIT] && !off_prev)
                off_cnt <= PCW'(DUMP_PW);
            else if (off_cnt != '0)
                off_cnt <= off_cnt - PCW'(1);
        end
    end

    assign dump_on  = (on_cnt != '0);
    assign dump_off = (off_cnt != '0);

endmodule

// File: tb/tb_scan_seq_engine.sv
// Randomized bench for scan_seq_engine: a trace-level model expands each
// channel table into the expected per-cycle out_word and dump pulses.
module tb_scan_seq_engine;

    localparam int         PW   = 4;
    localparam logic [7:0] IDLE = 8'h00;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic        ld_we   = 1'b0;
    logic [0:0]  ld_ch   = '0;
    logic [3:0]  ld_addr = '0;
    logic [27:0] ld_data = '0;
    logic        cfg_we  = 1'b0;
    logic [3:0]  cfg_last = '0;
    logic [7:0]  cfg_rep = '0;
    logic [0:0]  ch_sel  = '0;
    logic        start   = 1'b0;
    logic        abort   = 1'b0;
    logic [7:0]  out_word;
    logic        busy;
    logic [0:0]  act_ch;
    logic        done;
    logic        intr;
    logic        dump_on;
    logic        dump_off;
    logic        wr_err;

    scan_seq_engine dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .ld_we    (ld_we),
        .ld_ch    (ld_ch),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .cfg_we   (cfg_we),
        .cfg_last (cfg_last),
        .cfg_rep  (cfg_rep),
        .ch_sel   (ch_sel),
        .start    (start),
        .abort    (abort),
        .out_word (out_word),
        .busy     (busy),
        .act_ch   (act_ch),
        .done     (done),
        .intr     (intr),
        .dump_on  (dump_on),
        .dump_off (dump_off),
        .wr_err   (wr_err)
    );

    always #5 clk_sys = ~clk_sys;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         m_dur  [2][16];
    logic [7:0] m_word [2][16];
    int         m_last [2];
    int         m_rep  [2];
    logic [7:0] tq [$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic model_clear;
        for (int c = 0; c < 2; c++) begin
            m_last[c] = 0;
            m_rep[c]  = 0;
            for (int a = 0; a < 16; a++) begin
                m_dur[c][a]  = 0;
                m_word[c][a] = IDLE;
            end
        end
    endtask

    task automatic wr_step(int ch, int a, int d, logic [7:0] w);
        ld_we   = 1'b1;
        ld_ch   = ch[0:0];
        ld_addr = a[3:0];
        ld_data = {d[19:0], w};
        tick;
        ld_we = 1'b0;
        m_dur[ch][a]  = d;
        m_word[ch][a] = w;
    endtask

    task automatic wr_cfg(int ch, int last, int rep);
        cfg_we   = 1'b1;
        ld_ch    = ch[0:0];
        cfg_last = last[3:0];
        cfg_rep  = rep[7:0];
        tick;
        cfg_we = 1'b0;
        m_last[ch] = last;
        m_rep[ch]  = rep;
    endtask

    // Expected out_word per cycle from the first run cycle on, padded
    // with idle cycles so pulses trailing past the end are covered.
    task automatic build_trace(int ch, output int n);
        int d;
        tq.delete();
        for (int r = 0; r <= m_rep[ch]; r++)
            for (int k = 0; k <= m_last[ch]; k++) begin
                d = (m_dur[ch][k] == 0) ? 1 : m_dur[ch][k];
                repeat (d) tq.push_back(m_word[ch][k]);
            end
        n = tq.size();
        repeat (PW + 1) tq.push_back(IDLE);
    endtask

    // Pulse high at cycle i iff the bit rose in one of the PW cycles
    // before i (the cycle before the run shows IDLE).
    function automatic logic dump_exp(int i, int b);
        logic [7:0] prev, cur;
        for (int j = i - PW; j < i; j++) begin
            if (j >= 0) begin
                prev = (j == 0) ? IDLE : tq[j-1];
                cur  = tq[j];
                if (cur[b] && !prev[b]) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic run_seq(int ch, bit poke);
        int n;
        int sp;
        ch_sel = ch[0:0];
        repeat (PW + 1) tick;
        chk("act_ch_idle", 32'(act_ch), 32'(ch));
        build_trace(ch, n);
        sp = poke ? int'($urandom_range(0, n)) : -1;
        start = 1'b1;
        tick;
        start  = 1'b0;
        ch_sel = ~ch_sel;
        for (int i = 0; i < n + PW + 1; i++) begin
            chk("out_word", 32'(out_word), 32'(tq[i]));
            chk("busy", 32'(busy), 32'(i < n));
            chk("done", 32'(done), 32'(i == n));
            chk("intr", 32'(intr), 32'(i >= n));
            chk("dump_on", 32'(dump_on), 32'(dump_exp(i, 6)));
            chk("dump_off", 32'(dump_off), 32'(dump_exp(i, 7)));
            if (i <= n) chk("act_ch_frozen", 32'(act_ch), 32'(ch));
            start = (i == sp);
            tick;
        end
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_out"}, 32'(out_word), 32'(IDLE));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_wr_err"}, 32'(wr_err), 32'(0));
        chk({tag, "_don"}, 32'(dump_on), 32'(0));
        chk({tag, "_doff"}, 32'(dump_off), 32'(0));
        chk({tag, "_act_ch"}, 32'(act_ch), 32'(0));
        chk({tag, "_intr"}, 32'(intr), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ch, nw, k;
        model_clear();
        ch_sel = 1'b1;
        rst_n  = 1'b0;
        tick;
        tick;
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Two steps, single pass, then three passes.
        wr_step(0, 0, 5, 8'h01);
        wr_step(0, 1, 3, 8'h02);
        wr_cfg(0, 1, 0);
        run_seq(0, 1'b0);
        wr_cfg(0, 1, 2);
        run_seq(0, 1'b1);

        // Dump on rising bit 6, then unwritten entries beyond the table.
        wr_step(1, 0, 3, 8'h00);
        wr_step(1, 1, 6, 8'h40);
        wr_cfg(1, 1, 0);
        run_seq(1, 1'b0);
        wr_cfg(1, 4, 0);
        run_seq(1, 1'b0);

        // Abort three cycles into step 0 while a dump pulse is active.
        wr_step(0, 0, 5, 8'h40);
        wr_step(0, 1, 3, 8'h80);
        wr_cfg(0, 1, 0);
        ch_sel = 1'b0;
        repeat (PW + 1) tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("abort_step0", 32'(out_word), 32'(8'h40));
        tick;
        tick;
        chk("abort_pre_don", 32'(dump_on), 32'(1));
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_out", 32'(out_word), 32'(IDLE));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_don", 32'(dump_on), 32'(0));
        tick;
        chk("abort_done2", 32'(done), 32'(0));
        repeat (PW) tick;

        // start and abort together in idle: no run.
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'(0));
        chk("sa_out", 32'(out_word), 32'(IDLE));
        tick;
        chk("sa_busy2", 32'(busy), 32'(0));

        // Writes while ch1 runs: ch1 rejected, ch0 accepted.
        wr_step(1, 0, 10, 8'h05);
        wr_cfg(1, 0, 0);
        ch_sel = 1'b1;
        repeat (PW + 1) tick;
        start = 1'b1;
        tick;
        start   = 1'b0;
        ld_we   = 1'b1;
        ld_ch   = 1'b1;
        ld_addr = 4'd0;
        ld_data = {20'd3, 8'hAA};
        tick;
        chk("wr_err_ch1", 32'(wr_err), 32'(1));
        ld_ch   = 1'b0;
        ld_data = {20'd2, 8'h33};
        tick;
        ld_we = 1'b0;
        m_dur[0][0]  = 2;
        m_word[0][0] = 8'h33;
        chk("wr_ok_ch0", 32'(wr_err), 32'(0));
        cfg_we   = 1'b1;
        ld_ch    = 1'b1;
        cfg_last = 4'd3;
        cfg_rep  = 8'd5;
        tick;
        cfg_we = 1'b0;
        chk("cfg_err_ch1", 32'(wr_err), 32'(1));
        tick;
        chk("wr_err_pulse", 32'(wr_err), 32'(0));
        k = 0;
        while (!done && k < 40) begin
            tick;
            k++;
        end
        chk("wait_done", 32'(done), 32'(1));
        run_seq(1, 1'b0);
        run_seq(0, 1'b0);

        // Randomized tables and configs.
        for (int it = 0; it < 20; it++) begin
            ch = int'($urandom_range(0, 1));
            nw = int'($urandom_range(1, 8));
            for (int a = 0; a < nw; a++)
                wr_step(ch, a, int'($urandom_range(0, 6)),
                        8'($urandom_range(0, 255)));
            wr_cfg(ch, int'($urandom_range(0, 9)),
                   int'($urandom_range(0, 2)));
            run_seq(ch, 1'b1);
        end

        // Reset mid-run, then rerun against the cleared table.
        wr_step(0, 0, 8, 8'h40);
        wr_cfg(0, 0, 0);
        ch_sel = 1'b0;
        repeat (PW + 1) tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("pre_rst_busy", 32'(busy), 32'(1));
        ch_sel = 1'b1;
        rst_n  = 1'b0;
        tick;
        rst_n = 1'b1;
        chk_reset_vals("midrun_rst");
        model_clear();
        run_seq(0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_seq_engine.md
SCAN_SEQ_ENGINE -- requirements
Module: scan_seq_engine

Interface
REQ-001 SHALL have parameter NCH, default 2, number of independent sequence channels (scan, noise, ...).
REQ-002 SHALL have parameter DEPTH, default 16, steps per channel table (power of 2, >=2); AW = log2(DEPTH).
REQ-003 SHALL have parameter TW, default 20, step-duration width in clk_sys cycles.
REQ-004 SHALL have parameter OW, default 8, control-output word width.
REQ-005 SHALL have parameter IDLE_WORD, default 0, out_word value when not running.
REQ-006 SHALL have parameters DON_BIT (default 6), DOFF_BIT (default 7), DUMP_PW (default 4): dump trigger bit indices and dump pulse width in cycles.
REQ-007 clk_sys  in  1  single system clock; all logic on rising edge.
REQ-008 rst_n  in  1  synchronous, active-low reset.
REQ-009 ld_we  in  1  table write strobe, one entry per cycle.
REQ-010 ld_ch  in  log2(NCH) (min 1)  channel of write.
REQ-011 ld_addr  in  AW  step index of write.
REQ-012 ld_data  in  TW+OW  {duration[TW-1:0], word[OW-1:0]}.
REQ-013 cfg_we  in  1  writes cfg_last/cfg_rep for channel ld_ch.
REQ-014 cfg_last  in  AW  last step index; cfg_rep  in  8  extra repetitions (0 = run once).
REQ-015 ch_sel  in  log2(NCH)  requested active channel.
REQ-016 start  in  1  one-cycle start request; abort  in  1  one-cycle stop request.
REQ-017 out_word  out  OW  current step control word (soft_d, rt_sw, sw_acq1/2, ...).
REQ-018 busy  out  1  sequence running; act_ch  out  log2(NCH)  channel in use.
REQ-019 done  out  1  one-cycle pulse at normal completion; intr  out  1  level, = !busy (DSP interrupt).
REQ-020 dump_on, dump_off  out  1  dump pulses; wr_err  out  1  one-cycle pulse on rejected write.

Function
REQ-021 States SHALL be IDLE, RUN, DONE; DONE lasts exactly one cycle then IDLE.
REQ-022 In IDLE act_ch SHALL follow ch_sel each cycle; in RUN/DONE act_ch SHALL stay frozen.
REQ-023 start in IDLE (cycle t) SHALL give RUN, step 0, out_word = word[0], busy=1 at t+1.
REQ-024 Step k SHALL hold out_word for max(duration[k],1) cycles, then advance to k+1 on the next cycle with no gap.
REQ-025 After step cfg_last expires: if repeats remaining >0, decrement and go to step 0; else enter DONE, out_word=IDLE_WORD, busy=0, done=1.
REQ-026 start while RUN or DONE SHALL be ignored.
REQ-027 abort in RUN SHALL give IDLE next cycle, out_word=IDLE_WORD, busy=0, no done pulse; abort with start in same IDLE cycle: abort wins, no run.
REQ-028 Table/config writes to any channel other than act_ch SHALL always succeed; writes to act_ch while busy SHALL be dropped and wr_err pulsed one cycle.
REQ-029 Duration counter SHALL be TW bits, no wrap; duration all-ones SHALL give 2^TW-1 cycles.
REQ-030 Rising edge of out_word[DON_BIT] SHALL assert dump_on for exactly DUMP_PW cycles starting next cycle; same for DOFF_BIT/dump_off.
REQ-031 A new rising edge during an active dump pulse SHALL restart its DUMP_PW count.
REQ-032 abort SHALL clear both dump pulses next cycle.
REQ-033 cfg_last > table content written: unwritten entries SHALL read as duration 0, word IDLE_WORD.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, wr_err=0, dump_on=dump_off=0, out_word=IDLE_WORD, act_ch=0, intr=1, from any state including mid-RUN.
REQ-035 Reset SHALL clear all tables to 0/IDLE_WORD and all cfg_last/cfg_rep to 0.

Verification
REQ-036 ch0 steps {5,0x01},{3,0x02}, cfg_last=1, rep=0; start -> 0x01 for 5 cycles, 0x02 for 3, done pulse on 9th cycle after start+1, busy low.
REQ-037 Same table, rep=2 -> pattern 0x01/0x02 three times (24 cycles busy), single done.
REQ-038 Step word 0x40 after 0x00 -> dump_on high exactly 4 cycles starting one cycle after step entry; dump_off stays 0.
REQ-039 ch1 running, write ch1 addr 0 -> wr_err=1 one cycle, table unchanged; write ch0 same cycle path -> accepted.
REQ-040 abort 3 cycles into step 0 -> IDLE_WORD next cycle, no done; start+abort same cycle in IDLE -> stays IDLE.
REQ-041 rst_n low mid-RUN one cycle -> all outputs at reset values next cycle, rerun start reads zeroed table (1-cycle step, done after cfg_last=0).
